// File: rtl/dc_n_seq.sv
// dc_n_seq: W-to-2**W one-hot decoder with a registered, back-pressured output.
// Decode mode turns an offered select value into a one-hot result one cycle
// later. Scan mode steps the one-hot result through 0..N-1 once every DIV
// cycles. Both modes share one output register with a valid/ready handshake.
module dc_n_seq #(
  parameter int W   = 2,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        i,
  output logic [(1<<W)-1:0]   out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        idx,
  output logic                wrap
);

  localparam int N  = 1 << W;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0]  IDX_LAST = W'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {S_DEC = 1'b0, S_SCAN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          first_q, first_d;   // next scan result is the first since entry
  logic [N-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  idx_q, idx_d;
  logic          wrap_q, wrap_d;

  logic          free;       // output register may take a new value this cycle
  logic          tick;       // scan step is due (stays due until it can land)
  logic          accept;     // decode handshake completes
  logic          scan_load;  // scan step lands in the output register
  logic [W-1:0]  scan_idx;   // index of the scan result being loaded

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    free      = !valid_q || out_ready;
    tick      = (state_q == S_SCAN) && (div_q == DIV_LAST);
    in_ready  = rst_n && (state_q == S_DEC) && !mode && free;
    accept    = in_valid && in_ready;
    scan_load = tick && free;
    scan_idx  = first_q ? '0 : idx_q + W'(1);
  end

  // Mode FSM: switch direction only when the output register is free, so a
  // held result is never overwritten by the other mode.
  always_comb begin
    state_d = state_q;
    if (free) begin
      case (state_q)
        S_DEC:   if (mode)  state_d = S_SCAN;
        S_SCAN:  if (!mode) state_d = S_DEC;
        default: state_d = S_DEC;
      endcase
    end
  end

  // Scan divider: counts only in scan, parks on the last count while the
  // output is blocked so a pending step is neither lost nor doubled.
  always_comb begin
    div_d   = div_q;
    first_d = first_q;
    if (state_q != S_SCAN) begin
      div_d = '0;
    end else if (tick) begin
      div_d = free ? '0 : div_q;
    end else begin
      div_d = div_q + DW'(1);
    end
    if ((state_q == S_DEC) && (state_d == S_SCAN)) begin
      first_d = 1'b1;
    end else if (scan_load) begin
      first_d = 1'b0;
    end
  end

  // Output register: load a decode or scan result, hold under backpressure,
  // otherwise drain to empty (idx keeps the last index).
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (accept) begin
      out_d   = ONE_HOT0 << i;
      valid_d = 1'b1;
      idx_d   = i;
    end else if (scan_load) begin
      out_d   = ONE_HOT0 << scan_idx;
      valid_d = 1'b1;
      idx_d   = scan_idx;
      wrap_d  = !first_q && (idx_q == IDX_LAST);
    end else if (free) begin
      out_d   = '0;
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DEC;
      div_q   <= '0;
      first_q <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      first_q <= first_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule
